// File: rtl/nn_cfg_pkg.sv
// nn_cfg_pkg
// Shared configuration for the neural-network config loader and the neuron
// layer tops: default network shape, loader FSM state encoding and the width
// of the layer/neuron tags that travel with every broadcast config word.
// Layer entries are indexed from 0 (entry 0 describes layer 1).

package nn_cfg_pkg;

    localparam int NUM_LAYERS = 2;

    // Neurons per layer and weights per neuron in that layer.
    localparam int unsigned LAYER_NEURONS [NUM_LAYERS] = '{30, 10};
    localparam int unsigned LAYER_WEIGHTS [NUM_LAYERS] = '{784, 30};

    // Width of config_layer_num / config_neuron_num.
    localparam int CFG_TAG_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WEIGHT = 2'd1,
        BIAS   = 2'd2,
        DONE   = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/nn_cfg_loader.sv
// nn_cfg_loader
// Streams host configuration words into a multi-layer neural network. For
// every neuron of every layer the host sends LAYER_WEIGHTS[l] weights followed
// by one bias; each accepted word is rebroadcast one cycle later together with
// a (layer, neuron) tag so that only the addressed neuron latches it.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a full load (only looked at in IDLE)
//   s_data/s_valid      host config word and its valid flag
//   s_ready             loader accepts s_data this cycle (WEIGHT or BIAS)
//   weightValue/Valid   weight broadcast, Valid is a one-cycle qualifier
//   biasValue/Valid     bias broadcast, Valid is a one-cycle qualifier
//   config_layer_num    tag: target layer, numbered from 1
//   config_neuron_num   tag: target neuron within the layer, from 0
//   busy                a load is in progress (WEIGHT, BIAS, DONE)
//   done                one-cycle completion pulse, coincident with last bias

module nn_cfg_loader
    import nn_cfg_pkg::*;
#(
    parameter int          NUM_LAYERS                  = nn_cfg_pkg::NUM_LAYERS,
    parameter int          DATA_W                      = 32,
    parameter int unsigned LAYER_NEURONS [NUM_LAYERS]  = nn_cfg_pkg::LAYER_NEURONS,
    parameter int unsigned LAYER_WEIGHTS [NUM_LAYERS]  = nn_cfg_pkg::LAYER_WEIGHTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    weightValue,
    output logic                 weightValid,
    output logic [DATA_W-1:0]    biasValue,
    output logic                 biasValid,
    output logic [CFG_TAG_W-1:0] config_layer_num,
    output logic [CFG_TAG_W-1:0] config_neuron_num,
    output logic                 busy,
    output logic                 done
);

    function automatic int unsigned max_entry(input int unsigned a [NUM_LAYERS]);
        int unsigned m;
        m = 32'd0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (a[i] > m) begin
                m = a[i];
            end
        end
        return m;
    endfunction

    function automatic bit has_zero(input int unsigned a [NUM_LAYERS]);
        bit z;
        z = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (a[i] == 32'd0) begin
                z = 1'b1;
            end
        end
        return z;
    endfunction

    // The extra bit keeps the terminal count representable without wrap.
    localparam int WCNT_W = $clog2(max_entry(LAYER_WEIGHTS)) + 1;
    localparam int NCNT_W = $clog2(max_entry(LAYER_NEURONS)) + 1;
    localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    // A weightless layer would make the WEIGHT terminal count underflow.
    if (has_zero(LAYER_WEIGHTS)) begin : g_zero_weights
        $error("nn_cfg_loader: LAYER_WEIGHTS contains a zero entry");
    end

    cfg_state_t          state;
    logic [LIDX_W-1:0]   layer_idx;   // 0-based; tag is layer_idx + 1
    logic [NCNT_W-1:0]   neuron_cnt;
    logic [WCNT_W-1:0]   weight_cnt;

    logic                   xfer_s;
    logic                   last_weight_s;
    logic                   last_neuron_s;
    logic                   last_layer_s;
    logic [CFG_TAG_W-1:0]   tag_layer_s;
    logic [CFG_TAG_W-1:0]   tag_neuron_s;

    // Handshake, terminal-count decodes and the tag of the word being accepted.
    always_comb begin
        xfer_s        = s_valid & s_ready;
        last_weight_s = (32'(weight_cnt) == (LAYER_WEIGHTS[layer_idx] - 32'd1));
        last_neuron_s = (32'(neuron_cnt) == (LAYER_NEURONS[layer_idx] - 32'd1));
        last_layer_s  = (32'(layer_idx) == 32'(NUM_LAYERS - 1));
        tag_layer_s   = CFG_TAG_W'(layer_idx) + CFG_TAG_W'(1);
        tag_neuron_s  = CFG_TAG_W'(neuron_cnt);
    end

    // Load FSM, position counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            layer_idx         <= '0;
            neuron_cnt        <= '0;
            weight_cnt        <= '0;
            s_ready           <= 1'b0;
            weightValue       <= '0;
            weightValid       <= 1'b0;
            biasValue         <= '0;
            biasValid         <= 1'b0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            // Pulses default low; tags and values hold between transfers.
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WEIGHT;
                        layer_idx  <= '0;
                        neuron_cnt <= '0;
                        weight_cnt <= '0;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                WEIGHT: begin
                    if (xfer_s) begin
                        weightValid       <= 1'b1;
                        weightValue       <= s_data;
                        config_layer_num  <= tag_layer_s;
                        config_neuron_num <= tag_neuron_s;
                        if (last_weight_s) begin
                            state      <= BIAS;
                            weight_cnt <= '0;
                        end else begin
                            weight_cnt <= weight_cnt + WCNT_W'(1);
                        end
                    end
                end
                BIAS: begin
                    if (xfer_s) begin
                        biasValid         <= 1'b1;
                        biasValue         <= s_data;
                        config_layer_num  <= tag_layer_s;
                        config_neuron_num <= tag_neuron_s;
                        if (!last_neuron_s) begin
                            neuron_cnt <= neuron_cnt + NCNT_W'(1);
                            state      <= WEIGHT;
                        end else if (!last_layer_s) begin
                            layer_idx  <= layer_idx + LIDX_W'(1);
                            neuron_cnt <= '0;
                            state      <= WEIGHT;
                        end else begin
                            // Final bias: done rides alongside its pulse.
                            state   <= DONE;
                            done    <= 1'b1;
                            s_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    layer_idx  <= '0;
                    neuron_cnt <= '0;
                    weight_cnt <= '0;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_cfg_loader.sv
// tb_nn_cfg_loader
// Self-checking bench for nn_cfg_loader on a small 2-layer network
// (neurons {2,1}, weights per neuron {3,2} -> 11 words per load). The
// expected broadcast sequence is derived from nested layer/neuron/weight loops.

module tb_nn_cfg_loader;

    localparam int          NL                 = 2;
    localparam int unsigned TB_NEURONS [NL]    = '{2, 1};
    localparam int unsigned TB_WEIGHTS [NL]    = '{3, 2};
    localparam int          NWORDS             = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] weightValue;
    logic        weightValid;
    logic [31:0] biasValue;
    logic        biasValid;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    nn_cfg_loader #(
        .NUM_LAYERS    (NL),
        .DATA_W        (32),
        .LAYER_NEURONS (TB_NEURONS),
        .LAYER_WEIGHTS (TB_WEIGHTS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .weightValue       (weightValue),
        .weightValid       (weightValid),
        .biasValue         (biasValue),
        .biasValid         (biasValid),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Words of the current load and the expected broadcast sequence.
    logic [31:0] words [NWORDS];
    int          exp_kind   [$];
    logic [31:0] exp_val    [$];
    logic [31:0] exp_layer  [$];
    logic [31:0] exp_neuron [$];
    bit          exp_done   [$];

    // Observed broadcast sequence.
    int          cap_kind   [$];
    logic [31:0] cap_val    [$];
    logic [31:0] cap_layer  [$];
    logic [31:0] cap_neuron [$];
    bit          cap_done   [$];
    int          cap_cyc    [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          both_cnt = 0;
    logic        busy_after_done = 1'b1;
    bit          done_prev = 1'b0;

    // Monitor: record every output pulse away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (weightValid === 1'b1 && biasValid === 1'b1) both_cnt++;
        if (weightValid === 1'b1 || biasValid === 1'b1) begin
            cap_kind.push_back((biasValid === 1'b1) ? 1 : 0);
            cap_val.push_back((biasValid === 1'b1) ? biasValue : weightValue);
            cap_layer.push_back(config_layer_num);
            cap_neuron.push_back(config_neuron_num);
            cap_done.push_back(done === 1'b1);
            cap_cyc.push_back(cyc);
        end
        if (done_prev) busy_after_done = busy;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        done_prev = (done === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input int k, input logic [31:0] v,
                                     input int l, input int n, input bit d);
        exp_kind.push_back(k);
        exp_val.push_back(v);
        exp_layer.push_back(32'(l));
        exp_neuron.push_back(32'(n));
        exp_done.push_back(d);
    endfunction

    // Reference model: words are consumed weights-then-bias, neuron by
    // neuron, layer by layer; done accompanies the very last bias.
    function automatic void build_expected();
        int idx;
        idx = 0;
        exp_kind.delete(); exp_val.delete(); exp_layer.delete();
        exp_neuron.delete(); exp_done.delete();
        for (int l = 0; l < NL; l++) begin
            for (int n = 0; n < int'(TB_NEURONS[l]); n++) begin
                for (int w = 0; w < int'(TB_WEIGHTS[l]); w++) begin
                    push_exp(0, words[idx], l + 1, n, 1'b0);
                    idx++;
                end
                push_exp(1, words[idx], l + 1, n,
                         (l == NL - 1) && (n == int'(TB_NEURONS[l]) - 1));
                idx++;
            end
        end
    endfunction

    // Index of the first disagreement with the first n expected entries, -1 if none.
    function automatic int first_diff(input int n);
        if (cap_kind.size() != n) return (cap_kind.size() < n) ? cap_kind.size() : n;
        for (int i = 0; i < n; i++) begin
            if (cap_kind[i] != exp_kind[i] || cap_val[i] !== exp_val[i] ||
                cap_layer[i] !== exp_layer[i] || cap_neuron[i] !== exp_neuron[i] ||
                cap_done[i] != exp_done[i])
                return i;
        end
        return -1;
    endfunction

    task automatic clear_capture();
        cap_kind.delete(); cap_val.delete(); cap_layer.delete();
        cap_neuron.delete(); cap_done.delete(); cap_cyc.delete();
        done_cnt = 0;
        both_cnt = 0;
        busy_after_done = 1'b1;
    endtask

    task automatic seq_words();
        for (int i = 0; i < NWORDS; i++) words[i] = 32'(i + 1);
    endtask

    task automatic rand_words();
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feed n words. stall_mode: 0 back-to-back, 1 every other cycle, 2 random.
    // start is also raised while word start_on is being offered (-1 = never).
    task automatic drive_words(input int n, input int stall_mode, input int start_on);
        int  idx;
        int  guard;
        bit  v;
        bit  rdy;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 400) begin
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            s_valid = v;
            s_data  = v ? words[idx] : $urandom;
            start   = (idx == start_on);
            rdy     = s_ready;
            @(posedge clk); #1;
            if (v && rdy) idx++;
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        tests++;
        if (idx < n) begin
            fails++;
            $display("FAIL drive_timeout: accepted %0d words, required %0d", idx, n);
        end
    endtask

    task automatic run_load(input int stall_mode, input int start_on);
        clear_capture();
        build_expected();
        do_start();
        drive_words(NWORDS, stall_mode, start_on);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({s_ready, weightValid, biasValid, busy, done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 00000",
                     {s_ready, weightValid, biasValid, busy, done});
        end
        tests++;
        if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'd0) begin
            fails++;
            $display("FAIL reset_values: got %h %h %h %h required all 0",
                     weightValue, biasValue, config_layer_num, config_neuron_num);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_data();
        int bad_ready;
        bad_ready = 0;
        clear_capture();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            if (s_ready !== 1'b0) bad_ready++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bad_ready != 0) begin
            fails++;
            $display("FAIL idle_ready: s_ready high in %0d idle cycles, required 0", bad_ready);
        end
        tests++;
        if (cap_kind.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_pulses: %0d pulses busy=%b, required 0 pulses busy=0",
                     cap_kind.size(), busy);
        end
        tests++;
        if ({config_layer_num, config_neuron_num} !== 64'd0) begin
            fails++;
            $display("FAIL idle_tags: got %0d/%0d required 0/0",
                     config_layer_num, config_neuron_num);
        end
    endtask

    task automatic test_full_load();
        int d;
        seq_words();
        run_load(0, -1);
        d = first_diff(NWORDS);
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL full_seq: first difference at entry %0d (got %0d entries, required %0d)",
                     d, cap_kind.size(), NWORDS);
        end
        tests++;
        if (done_cnt != 1 || busy_after_done !== 1'b0) begin
            fails++;
            $display("FAIL full_done: done pulses %0d busy after %b, required 1 and 0",
                     done_cnt, busy_after_done);
        end
        tests++;
        if (cap_cyc.size() == 0 || done_cyc - (cap_cyc[0] - 1) != NWORDS) begin
            fails++;
            $display("FAIL full_timing: transfer-to-done span %0d required %0d",
                     (cap_cyc.size() == 0) ? -1 : done_cyc - (cap_cyc[0] - 1), NWORDS);
        end
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL full_exclusive: both valids high %0d times, required 0", both_cnt);
        end
    endtask

    task automatic test_backpressure();
        int d;
        seq_words();
        run_load(1, -1);
        d = first_diff(NWORDS);
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL bp_seq: first difference at entry %0d (got %0d entries)",
                     d, cap_kind.size());
        end
        tests++;
        if (done_cnt != 1 || cap_cyc.size() == 0 || done_cyc - (cap_cyc[0] - 1) != 21) begin
            fails++;
            $display("FAIL bp_timing: done pulses %0d span %0d, required 1 and 21",
                     done_cnt, (cap_cyc.size() == 0) ? -1 : done_cyc - (cap_cyc[0] - 1));
        end
    endtask

    task automatic test_reset_mid_load();
        int d;
        seq_words();
        clear_capture();
        build_expected();
        do_start();
        drive_words(5, 0, -1);
        // Sixth word is on offer while reset is sampled; it must be dropped.
        s_valid = 1'b1;
        s_data  = words[5];
        rst     = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy, s_ready, weightValid, biasValid, done} !== 5'b0 ||
            {weightValue, config_layer_num, config_neuron_num} !== 96'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: busy=%b ready=%b wv=%b bv=%b val=%h tag=%0d/%0d, required all 0",
                     busy, s_ready, weightValid, biasValid, weightValue,
                     config_layer_num, config_neuron_num);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        d = first_diff(5);
        tests++;
        if (d != -1 || done_cnt != 0) begin
            fails++;
            $display("FAIL rst_mid_seq: diff at %0d, %0d pulses, %0d done, required 5 pulses 0 done",
                     d, cap_kind.size(), done_cnt);
        end
        run_load(0, -1);
        d = first_diff(NWORDS);
        tests++;
        if (d != -1 || done_cnt != 1) begin
            fails++;
            $display("FAIL rst_reload: diff at %0d, done pulses %0d, required -1 and 1", d, done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int d;
        seq_words();
        run_load(0, 2);
        repeat (6) @(posedge clk);
        #1;
        d = first_diff(NWORDS);
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL busy_start_seq: first difference at entry %0d", d);
        end
        tests++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_done: done pulses %0d busy=%b, required 1 and 0",
                     done_cnt, busy);
        end
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 4; it++) begin
            rand_words();
            run_load(2, -1);
            d = first_diff(NWORDS);
            tests++;
            if (d != -1 || done_cnt != 1 || both_cnt != 0) begin
                fails++;
                $display("FAIL random_%0d: diff at %0d done %0d overlap %0d, required -1 1 0",
                         it, d, done_cnt, both_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 32'd0;
        test_reset();
        test_idle_data();
        test_full_load();
        test_backpressure();
        test_reset_mid_load();
        test_start_while_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
